// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   8N1 serial receiver, LSB first, OVERSAMPLE clocks per bit. The raw line
//   is synchronised, the start bit is validated at its midpoint, data and
//   stop bits are sampled one bit period apart, and each byte is presented
//   with a one-cycle data_valid strobe.
//
// Ports
//   clk_1843200hz  in   OVERSAMPLE x baud clock
//   reset          in   asynchronous, active-high reset
//   rx             in   raw serial line (asynchronous, idles high)
//   data           out  last received byte, first bit received in data[0]
//   data_valid     out  one-cycle strobe, data/framing_error updated
//   framing_error  out  stop bit sampled low; held until next data_valid
//   busy           out  receiver is in any state other than IDLE
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk_1843200hz,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CW-1:0]        r_cnt;
    logic [BCW-1:0]       r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;

    logic                 w_mid;
    logic                 w_end;
    logic                 w_all_bits;

    assign w_mid      = (r_cnt == CW'(OVERSAMPLE / 2 - 1));
    assign w_end      = (r_cnt == CW'(OVERSAMPLE - 1));
    assign w_all_bits = (r_bitcnt == BCW'(DATA_BITS));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!r_sync2) w_next = S_START;
            S_START: if (w_mid) w_next = r_sync2 ? S_IDLE : S_DATA;
            // Leaving DATA on the cycle after the last sample puts the stop
            // sample one full bit period plus one clock after bit 7.
            S_DATA:  if (w_all_bits) w_next = S_STOP;
            S_STOP:  if (w_end) w_next = r_sync2 ? S_IDLE : S_BREAK;
            S_BREAK: if (r_sync2) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_1843200hz or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_state <= w_next;
            r_valid <= 1'b0;

            // Within DATA the counter also restarts after each sample so
            // every bit is one bit period apart.
            if ((w_next != r_state) || (r_state == S_DATA && w_end))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);

            if (r_state == S_START && w_next == S_DATA)
                r_bitcnt <= '0;

            // Shifting in from the top leaves the first bit received in
            // bit 0 after DATA_BITS samples.
            if (r_state == S_DATA && w_end && !w_all_bits) begin
                r_shift  <= {r_sync2, r_shift[DATA_BITS-1:1]};
                r_bitcnt <= r_bitcnt + BCW'(1);
            end

            if (r_state == S_STOP && w_end) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_ferr  <= ~r_sync2;
            end
        end
    end

    assign data          = r_data;
    assign data_valid    = r_valid;
    assign framing_error = r_ferr;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk_1843200hz;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Strobe log filled by the monitor process.
    int         cyc      = 0;
    int         stb_cnt  = 0;
    int         busy_cyc = 0;
    logic [7:0] log_data [0:31];
    logic       log_fe   [0:31];
    int         log_cyc  [0:31];

    int fall_cyc;
    int base;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk_1843200hz (clk_1843200hz),
        .reset         (reset),
        .rx            (rx),
        .data          (data),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    initial clk_1843200hz = 1'b0;
    always #5 clk_1843200hz = ~clk_1843200hz;

    always begin
        @(posedge clk_1843200hz);
        cyc = cyc + 1;
        #1;
        if (data_valid && stb_cnt < 32) begin
            log_data[stb_cnt] = data;
            log_fe[stb_cnt]   = framing_error;
            log_cyc[stb_cnt]  = cyc;
            stb_cnt = stb_cnt + 1;
        end
        if (busy) busy_cyc = busy_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, then the stop level, which is left
    // on the line for the caller.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        #23;
        chk("reset_data",  data, 8'h00);
        chk("reset_valid", data_valid, 1'b0);
        chk("reset_ferr",  framing_error, 1'b0);
        chk("reset_busy",  busy, 1'b0);
        @(negedge clk_1843200hz);
        reset = 1'b0;
        repeat (10) @(negedge clk_1843200hz);
        chk("idle_busy", busy, 1'b0);

        // 0x55 with exact latency
        fall_cyc = cyc;
        send_frame(8'h55, 1'b1, 160);
        repeat (10) @(negedge clk_1843200hz);
        chk("55_count",   stb_cnt, 1);
        chk("55_data",    log_data[0], 8'h55);
        chk("55_ferr",    log_fe[0], 1'b0);
        chk("55_latency", log_cyc[0] - fall_cyc, 156);
        chk("55_busy",    busy, 1'b0);

        // back-to-back 0xA3, 0x0F
        send_frame(8'hA3, 1'b1, 160);
        send_frame(8'h0F, 1'b1, 160);
        repeat (10) @(negedge clk_1843200hz);
        chk("b2b_count", stb_cnt, 3);
        chk("b2b_data0", log_data[1], 8'hA3);
        chk("b2b_ferr0", log_fe[1], 1'b0);
        chk("b2b_data1", log_data[2], 8'h0F);
        chk("b2b_ferr1", log_fe[2], 1'b0);
        chk("b2b_gap",   log_cyc[2] - log_cyc[1], 160);

        // 5-cycle glitch
        repeat (10) @(negedge clk_1843200hz);
        busy_cyc = 0;
        rx = 1'b0;
        #50;
        rx = 1'b1;
        repeat (30) @(negedge clk_1843200hz);
        chk("glitch_busy_cycles", busy_cyc, 8);
        chk("glitch_no_strobe",   stb_cnt, 3);
        chk("glitch_idle",        busy, 1'b0);
        send_frame(8'h3C, 1'b1, 160);
        repeat (10) @(negedge clk_1843200hz);
        chk("3C_count", stb_cnt, 4);
        chk("3C_data",  log_data[3], 8'h3C);
        chk("3C_ferr",  log_fe[3], 1'b0);

        // framing error followed by a held-low line
        send_frame(8'h81, 1'b0, 160);
        #480;
        chk("fe_count",      stb_cnt, 5);
        chk("fe_data",       log_data[4], 8'h81);
        chk("fe_flag",       log_fe[4], 1'b1);
        chk("fe_break_busy", busy, 1'b1);
        chk("fe_held",       framing_error, 1'b1);
        rx = 1'b1;
        #320;
        chk("fe_no_extra", stb_cnt, 5);
        chk("fe_idle",     busy, 1'b0);
        send_frame(8'h7E, 1'b1, 160);
        repeat (10) @(negedge clk_1843200hz);
        chk("7E_count", stb_cnt, 6);
        chk("7E_data",  log_data[5], 8'h7E);
        chk("7E_ferr",  log_fe[5], 1'b0);

        // reset during bit 4 of 0xFF
        rx = 1'b0;
        #160;
        rx = 1'b1;
        #720;
        reset = 1'b1;
        #1;
        chk("rst_data",  data, 8'h00);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_ferr",  framing_error, 1'b0);
        chk("rst_busy",  busy, 1'b0);
        repeat (5) @(negedge clk_1843200hz);
        reset = 1'b0;
        repeat (200) @(negedge clk_1843200hz);
        chk("rst_no_strobe", stb_cnt, 6);
        chk("rst_data_held", data, 8'h00);
        send_frame(8'h12, 1'b1, 160);
        repeat (10) @(negedge clk_1843200hz);
        chk("12_count", stb_cnt, 7);
        chk("12_data",  log_data[6], 8'h12);
        chk("12_ferr",  log_fe[6], 1'b0);

        // bit period skew: 16.5 and 15.5 cycles per bit
        base = stb_cnt;
        send_frame(8'hC9, 1'b1, 165);
        repeat (20) @(negedge clk_1843200hz);
        send_frame(8'hC9, 1'b1, 155);
        repeat (20) @(negedge clk_1843200hz);
        chk("skew_count",     stb_cnt - base, 2);
        chk("skew_slow_data", log_data[7], 8'hC9);
        chk("skew_slow_ferr", log_fe[7], 1'b0);
        chk("skew_fast_data", log_data[8], 8'hC9);
        chk("skew_fast_ferr", log_fe[8], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
